// File: rtl/dio_upload.sv
// dio_upload -- HPS upload (readback) responder.
//
// Serves HPS byte reads from SDRAM so that disk images (possibly modified by
// the guest OS) can be saved back. Each even/odd byte pair maps to one
// 16-bit SDRAM word, which is fetched during a DIO bus slot. The word is
// split big-endian: the even byte is [15:8] and the odd byte is [7:0]. A
// one-word cache lets the odd byte of a pair be answered without another
// fetch. The HPS is held off through ioctl_wait while a fetch is pending.
//
// Ports
//   clk_sys        in   1   system clock, all logic on posedge
//   n_reset        in   1   synchronous reset, active-low
//   ioctl_upload   in   1   upload session active
//   ioctl_index    in   8   image select (0 ROM, 1 internal disk, 2 external disk)
//   ioctl_rd       in   1   one-cycle request for the byte at ioctl_addr
//   ioctl_addr     in   25  byte address within the image
//   ioctl_din      out  8   returned byte
//   ioctl_wait     out  1   high while the byte is not yet valid
//   dioBusControl  in   1   DIO memory slot active
//   mem_rd         out  1   SDRAM read request for the DIO slot
//   mem_addr       out  21  SDRAM word address
//   mem_dout       in   16  raw SDRAM word
module dio_upload #(
   parameter logic [20:0] OFFS1 = 21'h080000,
   parameter logic [20:0] OFFS2 = 21'h100000,
   parameter logic [7:0]  FILL  = 8'hFF
) (
   input  logic        clk_sys,
   input  logic        n_reset,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   input  logic        dioBusControl,
   output logic        mem_rd,
   output logic [20:0] mem_addr,
   input  logic [15:0] mem_dout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_SLOT = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] cache_word_r;
   logic [20:0] cache_tag_r;
   logic        cache_valid_r;
   logic        byte_sel_r;
   logic        upload_q_r;
   logic        dio_q_r;

   logic [20:0] offs_s;
   logic [20:0] wa_s;
   logic        unmapped_s;
   logic        upload_edge_s;
   logic        hit_s;
   logic        dio_fall_s;

   // Big-endian byte split: even address takes the high byte.
   function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic odd);
      sel_byte = odd ? word[7:0] : word[15:8];
   endfunction

   // Map the image index to its word offset and form the SDRAM word address.
   always_comb begin
      offs_s     = 21'h000000;
      unmapped_s = 1'b0;
      case (ioctl_index)
         8'd0:    offs_s = 21'h000000;
         8'd1:    offs_s = OFFS1;
         8'd2:    offs_s = OFFS2;
         default: unmapped_s = 1'b1;
      endcase
      // Sum is deliberately truncated to 21 bits so the address wraps.
      wa_s = ioctl_addr[21:1] + offs_s;
   end

   // Session edges, cache hit and DIO slot end detection.
   always_comb begin
      upload_edge_s = ioctl_upload ^ upload_q_r;
      // A session edge in this very cycle already invalidates the cache.
      hit_s         = cache_valid_r && !upload_edge_s && (cache_tag_r == wa_s);
      dio_fall_s    = dio_q_r && !dioBusControl;
   end

   // Request FSM, word cache and all registered outputs.
   always_ff @(posedge clk_sys) begin
      if (!n_reset) begin
         state_r       <= ST_IDLE;
         ioctl_din     <= 8'h00;
         ioctl_wait    <= 1'b0;
         mem_rd        <= 1'b0;
         mem_addr      <= 21'h000000;
         cache_word_r  <= 16'h0000;
         cache_tag_r   <= 21'h000000;
         cache_valid_r <= 1'b0;
         byte_sel_r    <= 1'b0;
         upload_q_r    <= 1'b0;
         dio_q_r       <= 1'b0;
      end else begin
         upload_q_r <= ioctl_upload;
         dio_q_r    <= dioBusControl;
         if (upload_edge_s) begin
            cache_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               ioctl_wait <= 1'b0;
               mem_rd     <= 1'b0;
               if (ioctl_rd && ioctl_upload) begin
                  if (unmapped_s) begin
                     ioctl_din <= FILL;
                  end else if (hit_s) begin
                     ioctl_din <= sel_byte(cache_word_r, ioctl_addr[0]);
                  end else begin
                     ioctl_wait <= 1'b1;
                     mem_addr   <= wa_s;
                     byte_sel_r <= ioctl_addr[0];
                     state_r    <= ST_ARM;
                  end
               end
            end
            ST_ARM: begin
               if (!ioctl_upload) begin
                  ioctl_wait <= 1'b0;
                  mem_rd     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else if (!dioBusControl) begin
                  // Only start on an idle bus so the request spans a whole slot.
                  mem_rd  <= 1'b1;
                  state_r <= ST_SLOT;
               end
            end
            ST_SLOT: begin
               if (!ioctl_upload) begin
                  ioctl_wait <= 1'b0;
                  mem_rd     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else if (dio_fall_s) begin
                  cache_word_r  <= mem_dout;
                  cache_tag_r   <= mem_addr;
                  cache_valid_r <= 1'b1;
                  ioctl_din     <= sel_byte(mem_dout, byte_sel_r);
                  ioctl_wait    <= 1'b0;
                  mem_rd        <= 1'b0;
                  state_r       <= ST_IDLE;
               end
            end
            default: begin
               ioctl_wait <= 1'b0;
               mem_rd     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
